// File: rtl/banner_scroller.sv
// Scrolling digit banner: a run-time loaded message shown through a DIGITS-wide
// window that rotates left/right, bounces or holds on each divider tick.
module banner_scroller #(
    parameter int DIGITS = 3,
    parameter int DEPTH  = 16,
    parameter int DW     = 5,
    parameter int AW     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic                 i_pause,
    input  logic [1:0]           i_mode,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [DW-1:0]        i_wr_data,
    input  logic                 i_len_wr,
    input  logic [AW:0]          i_len_data,
    output logic [DIGITS*DW-1:0] o_digits,
    output logic                 o_event
);

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'b00,
        MODE_RIGHT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    // A window wider than the store can never leave room to bounce.
    localparam logic [AW:0] SPAN    = (DIGITS >= DEPTH) ? DEPTH_L : (AW+1)'(DIGITS);

    logic [DW-1:0]        r_mem [DEPTH];
    logic [AW:0]          r_len;
    logic [AW:0]          r_pos;
    logic                 r_dir;
    logic [DIGITS*DW-1:0] r_digits;
    logic                 r_event;

    logic                 w_adv;
    logic [AW:0]          w_limit;
    logic [AW:0]          w_posNext;
    logic                 w_dirNext;
    logic                 w_evtNext;
    logic [AW:0]          w_idx [DIGITS];
    logic [DIGITS*DW-1:0] w_window;

    function automatic logic [AW:0] modLen(input logic [AW:0] x, input logic [AW:0] m);
        logic [AW:0] r;
        r = x;
        for (int i = 0; i < DEPTH; i++) begin
            if (m != '0 && r >= m) r = r - m;
        end
        return r;
    endfunction

    assign w_adv   = i_tick & ~i_pause & (mode_t'(i_mode) != MODE_HOLD);
    assign w_limit = (r_len > SPAN) ? (r_len - SPAN) : '0;

    always_comb begin
        w_posNext = r_pos;
        w_dirNext = r_dir;
        w_evtNext = 1'b0;
        if (i_len_wr) begin
            w_posNext = '0;
            w_dirNext = 1'b0;
        end else if (w_adv && r_len != '0) begin
            case (mode_t'(i_mode))
                MODE_LEFT: begin
                    if (r_pos + ONE < r_len) begin
                        w_posNext = r_pos + ONE;
                    end else begin
                        w_posNext = '0;
                        w_evtNext = 1'b1;
                    end
                end
                MODE_RIGHT: begin
                    if (r_pos >= r_len) begin
                        w_posNext = '0;
                        w_evtNext = 1'b1;
                    end else if (r_pos != '0) begin
                        w_posNext = r_pos - ONE;
                    end else begin
                        w_posNext = r_len - ONE;
                        w_evtNext = 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (r_pos > w_limit) begin
                        w_posNext = w_limit;
                        w_dirNext = 1'b1;
                    end else if (w_limit == '0) begin
                        w_posNext = r_pos;
                    end else if (!r_dir) begin
                        if (r_pos < w_limit) begin
                            w_posNext = r_pos + ONE;
                        end else begin
                            w_posNext = w_limit - ONE;
                            w_dirNext = 1'b1;
                            w_evtNext = 1'b1;
                        end
                    end else if (r_pos != '0) begin
                        w_posNext = r_pos - ONE;
                    end else begin
                        w_posNext = ONE;
                        w_dirNext = 1'b0;
                        w_evtNext = 1'b1;
                    end
                end
                default: begin
                    w_posNext = r_pos;
                end
            endcase
        end
    end

    // Each index stays below len, so memory reads never leave the loaded range.
    always_comb begin
        w_window = '1;
        w_idx[0] = modLen(r_pos, r_len);
        for (int k = 1; k < DIGITS; k++) begin
            w_idx[k] = (w_idx[k-1] + ONE == r_len) ? '0 : w_idx[k-1] + ONE;
        end
        if (r_len != '0) begin
            for (int k = 0; k < DIGITS; k++) begin
                w_window[(DIGITS-k)*DW-1 -: DW] = r_mem[w_idx[k][AW-1:0]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DW'(i[3:0]);
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_len    <= DEPTH_L;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_digits <= '1;
            r_event  <= 1'b0;
        end else begin
            if (i_len_wr) begin
                r_len <= (i_len_data > DEPTH_L) ? DEPTH_L : i_len_data;
            end
            r_pos    <= w_posNext;
            r_dir    <= w_dirNext;
            r_digits <= w_window;
            r_event  <= w_evtNext;
        end
    end

    assign o_digits = r_digits;
    assign o_event  = r_event;

endmodule

// File: tb/tb_banner_scroller.sv
// Directed self-checking bench for banner_scroller at default parameters.
module tb_banner_scroller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick;
    logic        pause;
    logic [1:0]  mode;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        len_wr;
    logic [4:0]  len_data;
    logic [14:0] digits;
    logic        evt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    banner_scroller dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_tick     (tick),
        .i_pause    (pause),
        .i_mode     (mode),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_len_wr   (len_wr),
        .i_len_data (len_data),
        .o_digits   (digits),
        .o_event    (evt)
    );

    function automatic logic [14:0] pack3(input int a, input int b, input int c);
        return {5'(a), 5'(b), 5'(c)};
    endfunction

    // One tick: event is sampled after the advancing edge, digits one edge later.
    task automatic applyStimulus(output logic evtSeen);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        evtSeen = evt;
        @(negedge clk);
    endtask

    task automatic loadLen(input logic [4:0] n);
        len_wr   = 1'b1;
        len_data = n;
        @(negedge clk);
        len_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (digits !== 15'h7FFF) begin
            failures++;
            $display("[TB] FAIL reset_blank: got %h expected %h", digits, 15'h7FFF);
        end
        checks++;
        if (evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_event: got %b expected 0", evt);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (digits !== pack3(0, 1, 2)) begin
            failures++;
            $display("[TB] FAIL reset_release: got %h expected %h", digits, pack3(0, 1, 2));
        end
    endtask

    task automatic test_rotate_left;
        logic e;
        mode = 2'b00;
        applyStimulus(e);
        checks++;
        if (digits !== pack3(1, 2, 3) || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL left_first: got %h/%b expected %h/0", digits, e, pack3(1, 2, 3));
        end
        for (int i = 2; i <= 15; i++) begin
            applyStimulus(e);
            checks++;
            if (e !== 1'b0) begin
                failures++;
                $display("[TB] FAIL left_noevent tick %0d: got %b expected 0", i, e);
            end
        end
        checks++;
        if (digits !== pack3(15, 0, 1)) begin
            failures++;
            $display("[TB] FAIL left_pos15: got %h expected %h", digits, pack3(15, 0, 1));
        end
        applyStimulus(e);
        checks++;
        if (e !== 1'b1 || digits !== pack3(0, 1, 2)) begin
            failures++;
            $display("[TB] FAIL left_wrap: got %h/%b expected %h/1", digits, e, pack3(0, 1, 2));
        end
        checks++;
        if (evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL left_pulse_width: got %b expected 0", evt);
        end
    endtask

    task automatic test_rotate_right;
        logic e;
        loadLen(5'd5);
        checks++;
        if (digits !== pack3(0, 1, 2)) begin
            failures++;
            $display("[TB] FAIL right_load: got %h expected %h", digits, pack3(0, 1, 2));
        end
        mode = 2'b01;
        applyStimulus(e);
        checks++;
        if (digits !== pack3(4, 0, 1) || e !== 1'b1) begin
            failures++;
            $display("[TB] FAIL right_wrap: got %h/%b expected %h/1", digits, e, pack3(4, 0, 1));
        end
        applyStimulus(e);
        checks++;
        if (digits !== pack3(3, 4, 0) || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL right_step: got %h/%b expected %h/0", digits, e, pack3(3, 4, 0));
        end
    endtask

    task automatic test_bounce;
        int   expPos [7] = '{1, 2, 3, 2, 1, 0, 1};
        logic expEvt [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic e;
        loadLen(5'd6);
        mode = 2'b10;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(e);
            checks++;
            if (digits !== pack3(expPos[i], (expPos[i] + 1) % 6, (expPos[i] + 2) % 6) || e !== expEvt[i]) begin
                failures++;
                $display("[TB] FAIL bounce step %0d: got %h/%b expected %h/%b", i, digits, e,
                         pack3(expPos[i], (expPos[i] + 1) % 6, (expPos[i] + 2) % 6), expEvt[i]);
            end
        end
    endtask

    task automatic test_pause_hold;
        logic e;
        logic anyEvt;
        anyEvt = 1'b0;
        pause  = 1'b1;
        mode   = 2'b00;
        repeat (10) begin
            applyStimulus(e);
            anyEvt |= e;
        end
        checks++;
        if (digits !== pack3(1, 2, 3) || anyEvt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pause: got %h/%b expected %h/0", digits, anyEvt, pack3(1, 2, 3));
        end
        pause = 1'b0;
        mode  = 2'b11;
        repeat (10) begin
            applyStimulus(e);
            anyEvt |= e;
        end
        checks++;
        if (digits !== pack3(1, 2, 3) || anyEvt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold: got %h/%b expected %h/0", digits, anyEvt, pack3(1, 2, 3));
        end
        mode = 2'b00;
    endtask

    task automatic test_priority;
        logic e;
        tick     = 1'b1;
        len_wr   = 1'b1;
        len_data = 5'd16;
        @(negedge clk);
        tick   = 1'b0;
        len_wr = 1'b0;
        checks++;
        if (evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lenwr_event: got %b expected 0", evt);
        end
        @(negedge clk);
        checks++;
        if (digits !== pack3(0, 1, 2)) begin
            failures++;
            $display("[TB] FAIL lenwr_over_tick: got %h expected %h", digits, pack3(0, 1, 2));
        end
        applyStimulus(e);
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 5'h09;
        @(negedge clk);
        wr_en   = 1'b0;
        reset_n = 1'b0;
        tick    = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checks++;
        if (digits !== 15'h7FFF || evt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_with_tick: got %h/%b expected %h/0", digits, evt, 15'h7FFF);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (digits !== pack3(0, 1, 2)) begin
            failures++;
            $display("[TB] FAIL reset_restore: got %h expected %h", digits, pack3(0, 1, 2));
        end
    endtask

    task automatic test_edge_lengths;
        logic e;
        logic anyEvt;
        mode = 2'b00;
        loadLen(5'd2);
        checks++;
        if (digits !== pack3(0, 1, 0)) begin
            failures++;
            $display("[TB] FAIL len2_window: got %h expected %h", digits, pack3(0, 1, 0));
        end
        applyStimulus(e);
        checks++;
        if (digits !== pack3(1, 0, 1) || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len2_step: got %h/%b expected %h/0", digits, e, pack3(1, 0, 1));
        end
        applyStimulus(e);
        checks++;
        if (digits !== pack3(0, 1, 0) || e !== 1'b1) begin
            failures++;
            $display("[TB] FAIL len2_wrap: got %h/%b expected %h/1", digits, e, pack3(0, 1, 0));
        end
        loadLen(5'd0);
        anyEvt = 1'b0;
        for (int m = 0; m < 3; m++) begin
            mode = 2'(m);
            applyStimulus(e);
            anyEvt |= e;
        end
        checks++;
        if (digits !== 15'h7FFF || anyEvt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL len0: got %h/%b expected %h/0", digits, anyEvt, 15'h7FFF);
        end
        loadLen(5'd31);
        mode = 2'b01;
        applyStimulus(e);
        checks++;
        if (digits !== pack3(15, 0, 1) || e !== 1'b1) begin
            failures++;
            $display("[TB] FAIL len_clamp: got %h/%b expected %h/1", digits, e, pack3(15, 0, 1));
        end
    endtask

    task automatic test_live_write;
        logic e;
        mode = 2'b00;
        applyStimulus(e);
        checks++;
        if (digits !== pack3(0, 1, 2) || e !== 1'b1) begin
            failures++;
            $display("[TB] FAIL write_setup: got %h/%b expected %h/1", digits, e, pack3(0, 1, 2));
        end
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 5'h1A;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (digits !== pack3(0, 1, 2)) begin
            failures++;
            $display("[TB] FAIL write_latency: got %h expected %h", digits, pack3(0, 1, 2));
        end
        @(negedge clk);
        checks++;
        if (digits !== pack3(0, 26, 2)) begin
            failures++;
            $display("[TB] FAIL write_visible: got %h expected %h", digits, pack3(0, 26, 2));
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        tick     = 1'b0;
        pause    = 1'b0;
        mode     = 2'b00;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        len_wr   = 1'b0;
        len_data = '0;
        @(negedge clk);
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_bounce();
        test_pause_hold();
        test_priority();
        test_edge_lengths();
        test_live_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
